// File: rtl/fetch_pkg.sv
// Shared fetch types and constants: FSM state encoding, reset vector, word alignment.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    EXC  = 3'd4
  } fetch_state_e;

  localparam logic [31:0]  RESET_VECTOR    = 32'hBFC00000;
  localparam int unsigned  WORD_ALIGN_BITS = 2;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bundle: Avalon-MM style instruction read bus plus the decode valid/ready port.
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              mem_read;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_waitrequest;
  logic [DATA_W-1:0] mem_readdata;
  logic              mem_readdatavalid;

  logic              instr_valid;
  logic [DATA_W-1:0] instr_data;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_ready;

  modport master (
    output mem_read, mem_addr,
    input  mem_waitrequest, mem_readdata, mem_readdatavalid,
    output instr_valid, instr_data, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  mem_read, mem_addr,
    output mem_waitrequest, mem_readdata, mem_readdatavalid,
    input  instr_valid, instr_data, instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/instr_out_reg.sv
// Holding register for the instruction presented to decode; load wins over clear.
module instr_out_reg #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [ADDR_W-1:0] pc_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] pc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pc_q    <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      pc_q    <= pc_i;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch: PC -> bus word read -> decode handshake, with flush discard.
// Optional misaligned-fetch exception enabled by defining FETCH_ALIGN_CHECK_EN.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              flush,
  output logic              pc_en,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic              fetch_exc,
`endif
  instr_fetch_unit_if.master bus
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK =
    ~((ADDR_W'(1) << WORD_ALIGN_BITS) - ADDR_W'(1));

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              discard_q, discard_d;
  logic              mem_read_q;

  logic              out_load, out_clr;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_pc;
  logic              out_valid;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_instr_pc;

`ifdef FETCH_ALIGN_CHECK_EN
  logic              exc_q, exc_d;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      discard_q  <= 1'b0;
      mem_read_q <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      exc_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      discard_q  <= discard_d;
      mem_read_q <= (state_d == REQ);
`ifdef FETCH_ALIGN_CHECK_EN
      exc_q      <= exc_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    discard_d = discard_q;
    out_load  = 1'b0;
    out_clr   = 1'b0;
    out_data  = '0;
    out_pc    = addr_q;
`ifdef FETCH_ALIGN_CHECK_EN
    exc_d     = exc_q;
`endif
    case (state_q)
      IDLE: begin
        addr_d  = pc_addr & ALIGN_MASK;
        state_d = REQ;
`ifdef FETCH_ALIGN_CHECK_EN
        if (pc_addr[WORD_ALIGN_BITS-1:0] != '0) begin
          state_d  = EXC;
          out_load = 1'b1;
          out_pc   = pc_addr;
          exc_d    = 1'b1;
        end
`endif
      end
      // Request cannot be withdrawn once raised; a flush here only marks the reply for discard.
      REQ: begin
        if (flush) discard_d = 1'b1;
        if (!bus.mem_waitrequest) state_d = WAIT;
      end
      WAIT: begin
        if (bus.mem_readdatavalid) begin
          if (discard_q || flush) begin
            discard_d = 1'b0;
            state_d   = IDLE;
          end else begin
            out_load = 1'b1;
            out_data = bus.mem_readdata;
            state_d  = HOLD;
          end
        end else if (flush) begin
          discard_d = 1'b1;
        end
      end
      HOLD: begin
        if (flush || bus.instr_ready) begin
          out_clr = 1'b1;
          state_d = IDLE;
        end
      end
`ifdef FETCH_ALIGN_CHECK_EN
      EXC: begin
        if (flush || bus.instr_ready) begin
          out_clr = 1'b1;
          exc_d   = 1'b0;
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  instr_out_reg #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_out_reg (
    .clk    (clk),
    .reset  (reset),
    .load_i (out_load),
    .clr_i  (out_clr),
    .data_i (out_data),
    .pc_i   (out_pc),
    .valid_o(out_valid),
    .data_o (out_instr),
    .pc_o   (out_instr_pc)
  );

  assign pc_en            = (state_q == HOLD) & bus.instr_ready & ~flush;
  assign bus.mem_read     = mem_read_q;
  assign bus.mem_addr     = addr_q;
  assign bus.instr_valid  = out_valid;
  assign bus.instr_data   = out_instr;
  assign bus.instr_pc     = out_instr_pc;
`ifdef FETCH_ALIGN_CHECK_EN
  assign fetch_exc        = exc_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: latency, stalls, back-pressure, flush discard, async reset.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] pc_addr;
  logic        flush;
  logic        pc_en;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_exc;
`endif

  int n_cmp = 0;
  int n_err = 0;

  instr_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  instr_fetch_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .pc_addr  (pc_addr),
    .flush    (flush),
    .pc_en    (pc_en),
`ifdef FETCH_ALIGN_CHECK_EN
    .fetch_exc(fetch_exc),
`endif
    .bus      (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".mem_read"},    64'(bus.mem_read),    64'd0);
    chk({tag, ".mem_addr"},    64'(bus.mem_addr),    64'd0);
    chk({tag, ".instr_valid"}, 64'(bus.instr_valid), 64'd0);
    chk({tag, ".instr_data"},  64'(bus.instr_data),  64'd0);
    chk({tag, ".instr_pc"},    64'(bus.instr_pc),    64'd0);
    chk({tag, ".pc_en"},       64'(pc_en),           64'd0);
  endtask

  initial begin
    reset                 = 1'b0;
    pc_addr               = RESET_VECTOR;
    flush                 = 1'b0;
    bus.mem_waitrequest   = 1'b0;
    bus.mem_readdata      = '0;
    bus.mem_readdatavalid = 1'b0;
    bus.instr_ready       = 1'b1;

    tick(); tick();
    #2 chk_zero("rst");
    reset = 1'b1;                                   // cycle 0: IDLE
    #2 chk("c0.mem_read", 64'(bus.mem_read), 64'd0);

    // Best-case fetch
    tick();                                          // cycle 1: REQ
    #2 chk("c1.mem_read", 64'(bus.mem_read), 64'd1);
    chk("c1.mem_addr", 64'(bus.mem_addr), 64'hBFC00000);
    tick();                                          // cycle 2: WAIT
    bus.mem_readdatavalid = 1'b1;
    bus.mem_readdata      = 32'h24080001;
    #2 chk("c2.mem_read", 64'(bus.mem_read), 64'd0);
    tick();                                          // cycle 3: HOLD
    bus.mem_readdatavalid = 1'b0;
    #2 chk("c3.instr_valid", 64'(bus.instr_valid), 64'd1);
    chk("c3.instr_data", 64'(bus.instr_data), 64'h24080001);
    chk("c3.instr_pc", 64'(bus.instr_pc), 64'hBFC00000);
    chk("c3.pc_en", 64'(pc_en), 64'd1);
    tick();                                          // cycle 4: IDLE, PC advanced
    pc_addr             = 32'hBFC00004;
    bus.mem_waitrequest = 1'b1;
    #2 chk("c4.pc_en", 64'(pc_en), 64'd0);
    chk("c4.instr_valid", 64'(bus.instr_valid), 64'd0);

    // Three waitrequest cycles: request held for four cycles
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) bus.mem_waitrequest = 1'b0;
      #2 chk("ws.mem_read", 64'(bus.mem_read), 64'd1);
      chk("ws.mem_addr", 64'(bus.mem_addr), 64'hBFC00004);
    end
    tick();                                          // WAIT
    bus.mem_readdatavalid = 1'b1;
    bus.mem_readdata      = 32'h3C1D1000;
    bus.instr_ready       = 1'b0;
    #2 chk("ws.wait_mem_read", 64'(bus.mem_read), 64'd0);

    // Decode back-pressure for five cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      bus.mem_readdatavalid = 1'b0;
      #2 chk("bp.instr_valid", 64'(bus.instr_valid), 64'd1);
      chk("bp.instr_data", 64'(bus.instr_data), 64'h3C1D1000);
      chk("bp.pc_en", 64'(pc_en), 64'd0);
    end
    tick();
    bus.instr_ready = 1'b1;
    #2 chk("bp.pc_en_pulse", 64'(pc_en), 64'd1);
    chk("bp.instr_pc", 64'(bus.instr_pc), 64'hBFC00004);
    tick();                                          // IDLE
    pc_addr = 32'hBFC00008;
    #2 chk("bp.after_valid", 64'(bus.instr_valid), 64'd0);
    chk("bp.after_pc_en", 64'(pc_en), 64'd0);

    // Flush in the same cycle as readdatavalid
    tick();                                          // REQ
    #2 chk("fw.mem_addr", 64'(bus.mem_addr), 64'hBFC00008);
    tick();                                          // WAIT
    bus.mem_readdatavalid = 1'b1;
    bus.mem_readdata      = 32'h8C090004;
    flush                 = 1'b1;
    #2 chk("fw.pc_en", 64'(pc_en), 64'd0);
    tick();                                          // IDLE, PC redirected
    bus.mem_readdatavalid = 1'b0;
    flush                 = 1'b0;
    pc_addr               = 32'hBFC00100;
    #2 chk("fw.instr_valid", 64'(bus.instr_valid), 64'd0);
    chk("fw.pc_en", 64'(pc_en), 64'd0);
    tick();                                          // REQ to redirected PC
    #2 chk("fw.mem_read", 64'(bus.mem_read), 64'd1);
    chk("fw.mem_addr_new", 64'(bus.mem_addr), 64'hBFC00100);

    // Async reset in the middle of WAIT
    tick();                                          // WAIT
    #2 reset = 1'b0;
    #1 chk_zero("ar");
    tick();
    reset                 = 1'b1;                    // IDLE, stale reply arrives late
    bus.mem_readdatavalid = 1'b1;
    bus.mem_readdata      = 32'hDEADBEEF;
    bus.mem_waitrequest   = 1'b1;
    #2 chk("ar.idle_valid", 64'(bus.instr_valid), 64'd0);
    tick();                                          // REQ, stalled
    #2 chk("ar.req_mem_read", 64'(bus.mem_read), 64'd1);
    chk("ar.req_mem_addr", 64'(bus.mem_addr), 64'hBFC00100);
    chk("ar.req_valid", 64'(bus.instr_valid), 64'd0);
    tick();                                          // REQ, accepted this cycle
    bus.mem_waitrequest   = 1'b0;
    bus.mem_readdatavalid = 1'b0;
    #2 chk("ar.req2_mem_read", 64'(bus.mem_read), 64'd1);
    tick();                                          // WAIT
    bus.mem_readdatavalid = 1'b1;
    bus.mem_readdata      = 32'h12345678;
    #2 chk("ar.wait_valid", 64'(bus.instr_valid), 64'd0);
    tick();                                          // HOLD
    bus.mem_readdatavalid = 1'b0;
    #2 chk("ar.instr_data", 64'(bus.instr_data), 64'h12345678);
    chk("ar.instr_pc", 64'(bus.instr_pc), 64'hBFC00100);
    chk("ar.pc_en", 64'(pc_en), 64'd1);
    tick();                                          // IDLE
    pc_addr = 32'hBFC00104;

    // Flush while the request is stalled: request stays up, reply dropped
    tick();                                          // REQ
    bus.mem_waitrequest = 1'b1;
    flush               = 1'b1;
    #2 chk("fr.mem_addr", 64'(bus.mem_addr), 64'hBFC00104);
    tick();                                          // REQ held
    flush               = 1'b0;
    bus.mem_waitrequest = 1'b0;
    #2 chk("fr.mem_read_held", 64'(bus.mem_read), 64'd1);
    tick();                                          // WAIT
    bus.mem_readdatavalid = 1'b1;
    bus.mem_readdata      = 32'hAAAA5555;
    #2 chk("fr.wait_mem_read", 64'(bus.mem_read), 64'd0);
    tick();                                          // IDLE, reply discarded
    bus.mem_readdatavalid = 1'b0;
    #2 chk("fr.instr_valid", 64'(bus.instr_valid), 64'd0);
    chk("fr.pc_en", 64'(pc_en), 64'd0);

`ifdef FETCH_ALIGN_CHECK_EN
    pc_addr         = 32'h00400002;
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();                                        // EXC
      #2 chk("ex.mem_read", 64'(bus.mem_read), 64'd0);
      chk("ex.fetch_exc", 64'(fetch_exc), 64'd1);
      chk("ex.instr_valid", 64'(bus.instr_valid), 64'd1);
      chk("ex.instr_data", 64'(bus.instr_data), 64'd0);
      chk("ex.instr_pc", 64'(bus.instr_pc), 64'h00400002);
    end
    bus.instr_ready = 1'b1;
    #1 chk("ex.pc_en", 64'(pc_en), 64'd0);
    tick();                                          // IDLE
    #2 chk("ex.exit_exc", 64'(fetch_exc), 64'd0);
    chk("ex.exit_valid", 64'(bus.instr_valid), 64'd0);
`else
    pc_addr = 32'hBFC00107;
    tick();                                          // REQ with low bits forced
    #2 chk("al.mem_read", 64'(bus.mem_read), 64'd1);
    chk("al.mem_addr", 64'(bus.mem_addr), 64'hBFC00104);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
